// File: rtl/fft_peak_detect.sv
// Captures a 16-bin FFT frame and reports the index of the largest |X[k]|^2 bin.
// Latency: done pulses 17 cycles after the accepting fft_valid edge; throughput one frame per 18 cycles.
// Backpressure: none; fft_valid during analysis is dropped and flagged on sticky overrun.
module fft_peak_detect #(
    parameter int NBIN = 16,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fft_valid,
    input  logic [2*DW-1:0] fft_d0,
    input  logic [2*DW-1:0] fft_d1,
    input  logic [2*DW-1:0] fft_d2,
    input  logic [2*DW-1:0] fft_d3,
    input  logic [2*DW-1:0] fft_d4,
    input  logic [2*DW-1:0] fft_d5,
    input  logic [2*DW-1:0] fft_d6,
    input  logic [2*DW-1:0] fft_d7,
    input  logic [2*DW-1:0] fft_d8,
    input  logic [2*DW-1:0] fft_d9,
    input  logic [2*DW-1:0] fft_d10,
    input  logic [2*DW-1:0] fft_d11,
    input  logic [2*DW-1:0] fft_d12,
    input  logic [2*DW-1:0] fft_d13,
    input  logic [2*DW-1:0] fft_d14,
    input  logic [2*DW-1:0] fft_d15,
    output logic            busy,
    output logic            done,
    output logic [3:0]      freq,
    output logic            overrun
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_q, state_d;

    logic [2*DW-1:0] din  [NBIN];
    logic [2*DW-1:0] bank [NBIN];

    logic [3:0]          idx_q;
    logic                tail_q;     // all bins squared; only the bin-15 compare remains
    logic                mag_vld_q;  // mag_q holds a bin awaiting comparison
    logic [2*DW-1:0]     mag_q;
    logic [3:0]          mag_idx_q;
    logic [2*DW-1:0]     max_q;
    logic [3:0]          arg_q;

    logic                accept;
    logic signed [DW-1:0]   re, im;
    logic signed [2*DW-1:0] re_sq, im_sq;
    logic [2*DW-1:0]        mag_c;
    logic                   better;
    logic [3:0]             arg_c;

    assign din[0]  = fft_d0;
    assign din[1]  = fft_d1;
    assign din[2]  = fft_d2;
    assign din[3]  = fft_d3;
    assign din[4]  = fft_d4;
    assign din[5]  = fft_d5;
    assign din[6]  = fft_d6;
    assign din[7]  = fft_d7;
    assign din[8]  = fft_d8;
    assign din[9]  = fft_d9;
    assign din[10] = fft_d10;
    assign din[11] = fft_d11;
    assign din[12] = fft_d12;
    assign din[13] = fft_d13;
    assign din[14] = fft_d14;
    assign din[15] = fft_d15;

    // A new frame can start from IDLE or from the single DONE cycle.
    assign accept = fft_valid && (state_q != CALC);
    assign busy   = (state_q == CALC);

    // Shared squarer pair on the bin selected by idx; each square is <= 2^30 so the sum fits unsigned 32 bits.
    always_comb begin
        re     = bank[idx_q][2*DW-1:DW];
        im     = bank[idx_q][DW-1:0];
        re_sq  = re * re;
        im_sq  = im * im;
        mag_c  = unsigned'(re_sq) + unsigned'(im_sq);
        better = mag_vld_q && (mag_q > max_q);
        arg_c  = better ? mag_idx_q : arg_q;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fft_valid) state_d = CALC;
            CALC:    if (tail_q)    state_d = DONE;
            DONE:    state_d = fft_valid ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame bank: loaded only when a frame is accepted, so dropped frames never disturb an analysis.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NBIN; i++) bank[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < NBIN; i++) bank[i] <= din[i];
        end
    end

    // Square-and-compare pipeline: square bin idx, compare the previous bin, publish after bin 15.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q     <= '0;
            tail_q    <= 1'b0;
            mag_vld_q <= 1'b0;
            mag_q     <= '0;
            mag_idx_q <= '0;
            max_q     <= '0;
            arg_q     <= '0;
            freq      <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fft_valid && state_q == CALC) overrun <= 1'b1;
            if (accept) begin
                idx_q     <= '0;
                tail_q    <= 1'b0;
                mag_vld_q <= 1'b0;
                max_q     <= '0;
                arg_q     <= '0;
            end else if (state_q == CALC) begin
                if (better) begin
                    max_q <= mag_q;
                    arg_q <= mag_idx_q;
                end
                if (!tail_q) begin
                    mag_q     <= mag_c;
                    mag_idx_q <= idx_q;
                    mag_vld_q <= 1'b1;
                    if (idx_q == 4'(NBIN - 1)) tail_q <= 1'b1;
                    else                       idx_q  <= idx_q + 4'd1;
                end else begin
                    freq      <= arg_c;
                    done      <= 1'b1;
                    idx_q     <= '0;
                    tail_q    <= 1'b0;
                    mag_vld_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: reset, peak search, ties, extreme magnitudes, overrun, mid-frame reset.
// Each scenario checks done latency and freq against hand-computed values.
// Inputs change #1 after a rising edge or on a falling edge; outputs are sampled on falling edges.
module tb_fft_peak_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fft_valid = 1'b0;
    logic [31:0] d [16];
    logic        busy, done, overrun;
    logic [3:0]  freq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fft_peak_detect dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
        .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
        .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
        .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
        .busy(busy), .done(done), .freq(freq), .overrun(overrun)
    );

    task automatic clear_d();
        for (int i = 0; i < 16; i++) d[i] = 32'h0;
    endtask

    // Returns #1 after the accepting edge E0.
    task automatic start_frame();
        @(posedge clk); #1 fft_valid = 1'b1;
        @(posedge clk); #1 fft_valid = 1'b0;
    endtask

    // Called #1 after edge En: returns k such that done is seen after edge E(n+k), or -1 if none.
    task automatic wait_done(input int max_cyc, output int lat);
        lat = -1;
        for (int i = 0; i <= max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (freq !== 4'd0)    begin bad++; $display("FAIL reset_freq got=%0d exp=0", freq); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_peak();
        int lat;
        clear_d();
        d[5] = 32'h0300_0400;
        start_frame();
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b exp=1", busy); end
        @(posedge clk); #1;
        wait_done(40, lat);
        lat = (lat < 0) ? lat : lat + 1;
        total++; if (lat !== 17)       begin bad++; $display("FAIL single_latency got=%0d exp=17", lat); end
        total++; if (freq !== 4'd5)    begin bad++; $display("FAIL single_freq got=%0d exp=5", freq); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL single_overrun got=%0b exp=0", overrun); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%0b exp=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%0b exp=0", busy); end
        repeat (5) @(negedge clk);
        total++; if (freq !== 4'd5) begin bad++; $display("FAIL single_freq_hold got=%0d exp=5", freq); end
    endtask

    task automatic test_tie();
        int lat;
        clear_d();
        d[3] = 32'h0100_0000;
        d[9] = 32'h0100_0000;
        start_frame();
        wait_done(40, lat);
        total++; if (lat !== 17)    begin bad++; $display("FAIL tie_latency got=%0d exp=17", lat); end
        total++; if (freq !== 4'd3) begin bad++; $display("FAIL tie_freq got=%0d exp=3", freq); end
    endtask

    task automatic test_extreme();
        int lat;
        clear_d();
        d[0]  = 32'h7FFF_7FFF;
        d[15] = 32'h8000_8000;
        start_frame();
        wait_done(40, lat);
        total++; if (lat !== 17)     begin bad++; $display("FAIL extreme_latency got=%0d exp=17", lat); end
        total++; if (freq !== 4'd15) begin bad++; $display("FAIL extreme_freq got=%0d exp=15", freq); end
    endtask

    task automatic test_all_zero();
        int lat;
        clear_d();
        start_frame();
        wait_done(40, lat);
        total++; if (lat !== 17)    begin bad++; $display("FAIL zero_latency got=%0d exp=17", lat); end
        total++; if (freq !== 4'd0) begin bad++; $display("FAIL zero_freq got=%0d exp=0", freq); end
    endtask

    task automatic test_back_to_back();
        int lat;
        clear_d();
        d[7] = 32'h0200_0000;
        start_frame();
        repeat (4) @(posedge clk);
        #1;
        clear_d();
        d[2] = 32'h0500_0000;
        fft_valid = 1'b1;
        @(posedge clk); #1 fft_valid = 1'b0;
        wait_done(40, lat);
        total++; if (lat !== 12)       begin bad++; $display("FAIL overrun_latency got=%0d exp=12", lat); end
        total++; if (freq !== 4'd7)    begin bad++; $display("FAIL overrun_freq got=%0d exp=7", freq); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%0b exp=1", overrun); end
        clear_d();
        d[11] = 32'h0000_0300;
        fft_valid = 1'b1;
        @(posedge clk); #1 fft_valid = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%0b exp=1", busy); end
        @(posedge clk); #1;
        wait_done(40, lat);
        lat = (lat < 0) ? lat : lat + 2;
        total++; if (lat !== 18)       begin bad++; $display("FAIL b2b_spacing got=%0d exp=18", lat); end
        total++; if (freq !== 4'd11)   begin bad++; $display("FAIL b2b_freq got=%0d exp=11", freq); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%0b exp=1", overrun); end
    endtask

    task automatic test_mid_reset();
        int lat;
        clear_d();
        d[6] = 32'h0100_0000;
        start_frame();
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL midrst_done got=%0b exp=0", done); end
        total++; if (freq !== 4'd0)    begin bad++; $display("FAIL midrst_freq got=%0d exp=0", freq); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midrst_overrun got=%0b exp=0", overrun); end
        @(posedge clk); #1 rst = 1'b1;
        wait_done(30, lat);
        total++; if (lat !== -1) begin bad++; $display("FAIL midrst_no_done got=%0d exp=-1", lat); end
        clear_d();
        d[9] = 32'h0000_0100;
        start_frame();
        wait_done(40, lat);
        total++; if (lat !== 17)    begin bad++; $display("FAIL midrst_recover_latency got=%0d exp=17", lat); end
        total++; if (freq !== 4'd9) begin bad++; $display("FAIL midrst_recover_freq got=%0d exp=9", freq); end
    endtask

    // Golden frames in which the DC bin dominates or ties for the peak.
    task automatic test_golden();
        int lat;
        for (int f = 0; f < 3; f++) begin
            clear_d();
            case (f)
                0: begin
                    d[0] = 32'h1000_0000;
                    for (int i = 1; i < 16; i++) d[i] = 32'h0100_0100;
                end
                1: for (int i = 0; i < 16; i++) d[i] = 32'h0040_FFC0;
                default: begin
                    d[0] = 32'h0000_8000;
                    d[8] = 32'h8000_0000;
                    d[4] = 32'h0100_FF00;
                end
            endcase
            start_frame();
            wait_done(40, lat);
            total++; if (lat !== 17)    begin bad++; $display("FAIL golden%0d_latency got=%0d exp=17", f, lat); end
            total++; if (freq !== 4'd0) begin bad++; $display("FAIL golden%0d_freq got=%0d exp=0", f, freq); end
        end
    endtask

    initial begin
        clear_d();
        test_reset();
        test_single_peak();
        test_tie();
        test_extreme();
        test_all_zero();
        test_back_to_back();
        test_mid_reset();
        test_golden();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
